// File: rtl/decode_issue_sequencer_pkg.sv
// Shared opcode constants, instruction-class and sequencer-state encodings
// for the decode issue sequencer.
package decode_issue_sequencer_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CALCI  = 7'b0010011;
  localparam logic [6:0] OP_CALC   = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LSU  = 2'd2,
    CLS_BR   = 2'd3
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

  // Maps an opcode to the reservation station it needs; unknown opcodes need only the ROB.
  function automatic instr_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE:                              classify = CLS_LSU;
      OP_JAL, OP_JALR, OP_BRANCH:                     classify = CLS_BR;
      OP_LUI, OP_AUIPC, OP_CALCI, OP_CALC, OP_FENCE:  classify = CLS_ALU;
      default:                                        classify = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_sequencer_instr_queue.sv
// Circular in-order instruction FIFO with synchronous flush; head data is
// presented combinationally from the read pointer.
module instr_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_head];
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_tail] <= din;
  end

endmodule

// File: rtl/decode_issue_sequencer.sv
// Buffers fetched instructions and fires one decode pulse per instruction,
// only when the ROB and the matching reservation station have room.
module decode_issue_sequencer
  import decode_issue_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STALLW = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      fetch_valid,
  input  logic [XLEN-1:0]           fetch_instr,
  input  logic [XLEN-1:0]           fetch_pc,
  output logic                      fetch_ready,
  input  logic                      rob_free,
  input  logic                      alu_rs_free,
  input  logic                      lsu_rs_free,
  input  logic                      br_rs_free,
  input  logic                      flush,
  output logic                      decode_pulse,
  output logic                      decode_available,
  output logic [XLEN-1:0]           decode_instr,
  output logic [XLEN-1:0]           decode_pc,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [STALLW-1:0]         stall_count
);

  localparam int unsigned EW = 2 * XLEN;

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic              w_pop;
  logic              w_push;
  logic [EW-1:0]     w_q_dout;
  logic              w_q_full;
  logic              w_q_empty;
  instr_class_e      w_head_class;
  logic              w_rs_ok;
  logic              w_head_ok;
  logic              w_stall_inc;
  logic [XLEN-1:0]   r_decode_instr;
  logic [XLEN-1:0]   r_decode_pc;
  logic [STALLW-1:0] r_stall;

  assign w_push = fetch_valid && !w_q_full && !flush;

  instr_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_instr_queue (
    .clock (clock),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({fetch_instr, fetch_pc}),
    .dout  (w_q_dout),
    .count (q_count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  assign w_head_class = classify(w_q_dout[XLEN+6:XLEN]);

  always_comb begin
    w_rs_ok = 1'b1;
    case (w_head_class)
      CLS_ALU: w_rs_ok = alu_rs_free;
      CLS_LSU: w_rs_ok = lsu_rs_free;
      CLS_BR:  w_rs_ok = br_rs_free;
      default: w_rs_ok = 1'b1;
    endcase
  end

  assign w_head_ok = !w_q_empty && rob_free && w_rs_ok;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // PULSE is always followed by SETTLE so decoder-side updates reach the free inputs.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE, ST_SETTLE: begin
        if (w_head_ok) begin
          w_next = ST_PULSE;
          w_pop  = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_PULSE: w_next = ST_SETTLE;
      default:  w_next = ST_IDLE;
    endcase
    if (flush) begin
      w_next = ST_IDLE;
      w_pop  = 1'b0;
    end
  end

  assign w_stall_inc = ((r_state == ST_IDLE) || (r_state == ST_SETTLE)) &&
                       !w_q_empty && !w_head_ok;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_decode_instr <= '0;
      r_decode_pc    <= '0;
      r_stall        <= '0;
    end else begin
      if (w_pop) begin
        r_decode_instr <= w_q_dout[EW-1:XLEN];
        r_decode_pc    <= w_q_dout[XLEN-1:0];
      end
      if (w_stall_inc && (r_stall != '1)) r_stall <= r_stall + STALLW'(1);
    end
  end

  assign decode_pulse     = (r_state == ST_PULSE);
  assign decode_available = decode_pulse;
  assign decode_instr     = r_decode_instr;
  assign decode_pc        = r_decode_pc;
  assign stall_count      = r_stall;
  assign fetch_ready      = !w_q_full;

endmodule

// File: tb/tb_decode_issue_sequencer.sv
// Directed self-checking bench for decode_issue_sequencer.
module tb_decode_issue_sequencer;

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STALLW = 16;

  logic              clock;
  logic              rst_n;
  logic              fetch_valid;
  logic [XLEN-1:0]   fetch_instr;
  logic [XLEN-1:0]   fetch_pc;
  logic              fetch_ready;
  logic              rob_free;
  logic              alu_rs_free;
  logic              lsu_rs_free;
  logic              br_rs_free;
  logic              flush;
  logic              decode_pulse;
  logic              decode_available;
  logic [XLEN-1:0]   decode_instr;
  logic [XLEN-1:0]   decode_pc;
  logic [2:0]        q_count;
  logic [STALLW-1:0] stall_count;

  int n_checks;
  int n_errors;

  decode_issue_sequencer #(
    .QDEPTH (QDEPTH),
    .XLEN   (XLEN),
    .STALLW (STALLW)
  ) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_instr      (fetch_instr),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .rob_free         (rob_free),
    .alu_rs_free      (alu_rs_free),
    .lsu_rs_free      (lsu_rs_free),
    .br_rs_free       (br_rs_free),
    .flush            (flush),
    .decode_pulse     (decode_pulse),
    .decode_available (decode_available),
    .decode_instr     (decode_instr),
    .decode_pc        (decode_pc),
    .q_count          (q_count),
    .stall_count      (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    rob_free = 1'b1; alu_rs_free = 1'b1; lsu_rs_free = 1'b1; br_rs_free = 1'b1;
    flush = 1'b0;
    step(); step();
    n_checks++;
    if ({decode_pulse, decode_available, q_count, stall_count, fetch_ready} !== {1'b0, 1'b0, 3'd0, 16'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_ctrl: pulse=%b avail=%b q=%0d stall=%0d ready=%b, want 0 0 0 0 1",
               decode_pulse, decode_available, q_count, stall_count, fetch_ready);
    end
    n_checks++;
    if (decode_instr !== 32'h0 || decode_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_data: instr=%h pc=%h, want 0 0", decode_instr, decode_pc);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_issue();
    fetch_valid = 1'b1; fetch_instr = 32'h00500093; fetch_pc = 32'h00000100;
    step();
    fetch_valid = 1'b0;
    n_checks++;
    if (decode_pulse !== 1'b0 || q_count !== 3'd1) begin
      n_errors++;
      $display("FAIL single_push: pulse=%b q=%0d, want 0 1", decode_pulse, q_count);
    end
    step();
    n_checks++;
    if ({decode_pulse, decode_available, decode_instr, decode_pc} !== {1'b1, 1'b1, 32'h00500093, 32'h00000100}) begin
      n_errors++;
      $display("FAIL single_pulse: pulse=%b avail=%b instr=%h pc=%h, want 1 1 00500093 00000100",
               decode_pulse, decode_available, decode_instr, decode_pc);
    end
    step();
    n_checks++;
    if (decode_pulse !== 1'b0 || decode_instr !== 32'h00500093) begin
      n_errors++;
      $display("FAIL single_after: pulse=%b instr=%h, want 0 00500093", decode_pulse, decode_instr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] instrs [4];
    int exp_stall;
    instrs[0] = 32'h00100113; instrs[1] = 32'h00200193;
    instrs[2] = 32'h00300213; instrs[3] = 32'h00400293;
    rob_free = 1'b0;
    exp_stall = 0;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1; fetch_instr = instrs[i]; fetch_pc = 32'h200 + 32'(4 * i);
      step();
      if (i > 0) exp_stall++;
    end
    n_checks++;
    if (fetch_ready !== 1'b0 || q_count !== 3'd4) begin
      n_errors++;
      $display("FAIL b2b_full: ready=%b q=%0d, want 0 4", fetch_ready, q_count);
    end
    fetch_instr = 32'h00500313; fetch_pc = 32'h210;
    step();
    exp_stall++;
    fetch_valid = 1'b0;
    n_checks++;
    if (q_count !== 3'd4 || decode_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_fifth: q=%0d pulse=%b, want 4 0", q_count, decode_pulse);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      exp_stall++;
      n_checks++;
      if (stall_count !== 16'(exp_stall) || decode_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_stall: stall=%0d pulse=%b, want %0d 0", stall_count, decode_pulse, exp_stall);
      end
    end
    rob_free = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (decode_pulse !== 1'b1 || decode_instr !== instrs[i] || q_count !== 3'(3 - i)) begin
        n_errors++;
        $display("FAIL b2b_order%0d: pulse=%b instr=%h q=%0d, want 1 %h %0d",
                 i, decode_pulse, decode_instr, q_count, instrs[i], 3 - i);
      end
      step();
      n_checks++;
      if (decode_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_gap%0d: pulse=%b, want 0", i, decode_pulse);
      end
    end
    step();
    n_checks++;
    if (stall_count !== 16'd6 || q_count !== 3'd0) begin
      n_errors++;
      $display("FAIL b2b_end: stall=%0d q=%0d, want 6 0", stall_count, q_count);
    end
  endtask

  task automatic test_lsu_stall();
    lsu_rs_free = 1'b0; alu_rs_free = 1'b1;
    fetch_valid = 1'b1; fetch_instr = 32'h00002083; fetch_pc = 32'h300;
    step();
    fetch_valid = 1'b0;
    step(); step();
    n_checks++;
    if (decode_pulse !== 1'b0 || stall_count !== 16'd8) begin
      n_errors++;
      $display("FAIL lsu_stall: pulse=%b stall=%0d, want 0 8", decode_pulse, stall_count);
    end
    lsu_rs_free = 1'b1;
    step();
    n_checks++;
    if (decode_pulse !== 1'b1 || decode_instr !== 32'h00002083 || decode_pc !== 32'h300) begin
      n_errors++;
      $display("FAIL lsu_pulse: pulse=%b instr=%h pc=%h, want 1 00002083 300",
               decode_pulse, decode_instr, decode_pc);
    end
    step(); step();
    n_checks++;
    if (stall_count !== 16'd8) begin
      n_errors++;
      $display("FAIL lsu_end: stall=%0d, want 8", stall_count);
    end
  endtask

  task automatic test_flush();
    rob_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; fetch_instr = 32'h00A00013 + 32'(i << 7); fetch_pc = 32'h400 + 32'(4 * i);
      step();
    end
    fetch_valid = 1'b0;
    rob_free = 1'b1;
    step();
    n_checks++;
    if (decode_pulse !== 1'b1 || decode_instr !== 32'h00A00013 || q_count !== 3'd2) begin
      n_errors++;
      $display("FAIL flush_pre: pulse=%b instr=%h q=%0d, want 1 00a00013 2", decode_pulse, decode_instr, q_count);
    end
    flush = 1'b1; fetch_valid = 1'b1; fetch_instr = 32'h00F00013; fetch_pc = 32'h4F0;
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    n_checks++;
    if (decode_pulse !== 1'b0 || q_count !== 3'd0 || decode_instr !== 32'h00A00013 || decode_pc !== 32'h400) begin
      n_errors++;
      $display("FAIL flush_edge: pulse=%b q=%0d instr=%h pc=%h, want 0 0 00a00013 400",
               decode_pulse, q_count, decode_instr, decode_pc);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (decode_pulse !== 1'b0 || q_count !== 3'd0) begin
        n_errors++;
        $display("FAIL flush_quiet%0d: pulse=%b q=%0d, want 0 0", i, decode_pulse, q_count);
      end
    end
    n_checks++;
    if (stall_count !== 16'd10) begin
      n_errors++;
      $display("FAIL flush_stall: stall=%0d, want 10", stall_count);
    end
  endtask

  task automatic test_async_reset();
    rob_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; fetch_instr = 32'h01000013 + 32'(i << 7); fetch_pc = 32'h500 + 32'(4 * i);
      step();
    end
    fetch_valid = 1'b0;
    rob_free = 1'b1;
    step();
    step();
    n_checks++;
    if (decode_pulse !== 1'b0 || q_count !== 3'd2 || stall_count !== 16'd12) begin
      n_errors++;
      $display("FAIL arst_pre: pulse=%b q=%0d stall=%0d, want 0 2 12", decode_pulse, q_count, stall_count);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({decode_pulse, decode_available, q_count, stall_count, fetch_ready, decode_instr, decode_pc} !==
        {1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 32'h0, 32'h0}) begin
      n_errors++;
      $display("FAIL arst_mid: pulse=%b avail=%b q=%0d stall=%0d ready=%b instr=%h pc=%h, want 0 0 0 0 1 0 0",
               decode_pulse, decode_available, q_count, stall_count, fetch_ready, decode_instr, decode_pc);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (decode_pulse !== 1'b0 || q_count !== 3'd0) begin
        n_errors++;
        $display("FAIL arst_after%0d: pulse=%b q=%0d, want 0 0", i, decode_pulse, q_count);
      end
    end
  endtask

  task automatic test_stall_saturate();
    rob_free = 1'b0;
    fetch_valid = 1'b1; fetch_instr = 32'h00000033; fetch_pc = 32'h600;
    step();
    fetch_valid = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    n_checks++;
    if (stall_count !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sat_near: stall=%h, want fffe", stall_count);
    end
    for (int i = 0; i < 70000 - 65534; i++) step();
    n_checks++;
    if (stall_count !== 16'hFFFF || decode_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_hold: stall=%h pulse=%b, want ffff 0", stall_count, decode_pulse);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_lsu_stall();
    test_flush();
    test_async_reset();
    test_stall_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
